memory_stage: RTL and testbench

- MEM stage of the CPU pipeline, directly downstream of the EX/MEM pipeline register; consumes its alu_result, memaddr, rd and alu_op outputs.
- Runs load/store transactions to data memory over a req/ack handshake with variable latency.
- Passes non-memory results straight through.
- Drives stall_out to freeze upstream registers, and registers its result for the MEM/WB register.

---
 rtl/memory_stage.sv | 138 +++++++++++++
 tb/tb_memory_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the CPU pipeline.
//   Non-memory ops pass through to the MEM/WB register in one cycle. Loads
//   and stores run a registered req/ack transaction with variable latency.
//   Each transaction is abandoned after TIMEOUT request cycles, and a timeout
//   sets a sticky bus_error.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   halted               global halt; wb_* hold while high
//   alu_result_in        ALU result / store data
//   memaddr_in, rd_in    word address, destination register
//   alu_op_in            operation code
//   mem_req/we/addr/wdata registered memory request
//   mem_rdata, mem_ack   load data, one-cycle completion pulse
//   stall_out            combinational upstream freeze
//   wb_data/rd/we        registered result to MEM/WB
//   bus_error            sticky timeout flag
module memory_stage #(
  parameter logic [4:0] OP_LOAD  = 5'd20,
  parameter logic [4:0] OP_STORE = 5'd21,
  parameter logic [4:0] OP_NOP   = 5'd0,
  parameter int         TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halted,
  input  logic [31:0] alu_result_in,
  input  logic [16:0] memaddr_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  alu_op_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        bus_error
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wb_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      req_rd;   // destination of the in-flight memory op
  wb_t             held;     // completed result parked while halted
  wb_t             res;
  logic            is_mem, tmo, complete;

  assign is_mem   = (alu_op_in == OP_LOAD) || (alu_op_in == OP_STORE);
  assign tmo      = (state == REQ) && (cnt == CW'(TIMEOUT - 1));
  assign complete = (state == REQ) && (mem_ack || tmo);

  // Completion result; a timeout without ack yields a dead (we=0) zero result.
  // An ack in the timeout cycle still wins.
  always_comb begin
    res.rd   = req_rd;
    res.data = '0;
    res.we   = 1'b0;
    if (mem_ack && !mem_we) begin
      res.data = mem_rdata;
      res.we   = (req_rd != 5'd0);
    end
  end

  assign stall_out = ((state == IDLE) && is_mem) ||
                     ((state == REQ) && !complete) ||
                     ((state == DONE) && halted);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_rd    <= '0;
      held      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Memory ops launch even while halted; only wb_* respect halt.
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (alu_op_in == OP_STORE);
            mem_addr  <= memaddr_in;
            mem_wdata <= alu_result_in;
            req_rd    <= rd_in;
            cnt       <= '0;
            state     <= REQ;
          end else if (!halted) begin
            wb_data <= alu_result_in;
            wb_rd   <= rd_in;
            wb_we   <= (alu_op_in != OP_NOP) && (rd_in != 5'd0);
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (complete) begin
            mem_req <= 1'b0;
            if (!mem_ack) bus_error <= 1'b1;
            if (halted) begin
              held  <= res;
              state <= DONE;
            end else begin
              wb_data <= res.data;
              wb_rd   <= res.rd;
              wb_we   <= res.we;
              state   <= IDLE;
            end
          end
        end
        DONE: begin
          if (!halted) begin
            wb_data <= held.data;
            wb_rd   <= held.rd;
            wb_we   <= held.we;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam int TMO = 4;
  localparam logic [4:0] LD = 5'd20, ST = 5'd21;

  logic        clk = 1'b0, reset = 1'b1, halted = 1'b0;
  logic [31:0] alu_result_in = '0, mem_rdata = '0;
  logic [16:0] memaddr_in = '0;
  logic [4:0]  rd_in = '0, alu_op_in = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, stall_out, wb_we, bus_error;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, wb_data;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .halted(halted),
    .alu_result_in(alu_result_in), .memaddr_in(memaddr_in), .rd_in(rd_in),
    .alu_op_in(alu_op_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall_out(stall_out), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .bus_error(bus_error)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] alu;
    logic [16:0] addr;
    logic [4:0]  rd;
    int          ackdly;   // ack in REQ cycle number ackdly (0-based); >=TMO never
    logic [31:0] rdata;
    logic [31:0] xdata;
    logic [4:0]  xrd;
    logic        xwe;
    int          xstall;
    logic        xberr;
  } vec_t;

  int   nvec = 0, nerr = 0;
  logic berr_m = 1'b0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation: what MEM/WB should hold after the op retires.
  function automatic vec_t model(input logic [4:0] op, input logic [31:0] alu,
                                 input logic [16:0] addr, input logic [4:0] rd,
                                 input int ackdly, input logic [31:0] rdata);
    vec_t v;
    v.op = op; v.alu = alu; v.addr = addr; v.rd = rd; v.ackdly = ackdly; v.rdata = rdata;
    v.xrd = rd;
    if (op != LD && op != ST) begin
      v.xdata = alu; v.xwe = (op != 5'd0) && (rd != 5'd0); v.xstall = 0;
    end else if (ackdly < TMO) begin
      v.xstall = 1 + ackdly;
      v.xdata  = (op == LD) ? rdata : 32'd0;
      v.xwe    = (op == LD) && (rd != 5'd0);
    end else begin
      v.xstall = TMO; v.xdata = 32'd0; v.xwe = 1'b0; berr_m = 1'b1;
    end
    v.xberr = berr_m;
    return v;
  endfunction

  // Starts and ends on a negedge; acts as upstream (holds op while stalled)
  // and as the memory responder.
  task automatic run_op(input vec_t v, input string tag);
    int reqc = 0, stalls = 0, cyc = 0;
    logic st, wasreq, done = 1'b0;
    alu_op_in = v.op; alu_result_in = v.alu; memaddr_in = v.addr;
    rd_in = v.rd; mem_rdata = v.rdata;
    while (!done && cyc < 20) begin
      mem_ack = mem_req && (reqc == v.ackdly);
      #1;
      if (mem_req && reqc == 0) begin
        chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, v.op == ST});
        chk({tag, ".mem_addr"}, {15'd0, mem_addr}, {15'd0, v.addr});
        chk({tag, ".mem_wdata"}, mem_wdata, v.alu);
      end
      st = stall_out;
      if (st) stalls++;
      wasreq = mem_req;
      @(posedge clk);
      if (wasreq) reqc++;
      @(negedge clk);
      mem_ack = 1'b0;
      cyc++;
      if (!st) done = 1'b1;
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL %s.retire: got no retire expected retire within 20 cycles", tag);
    end
    chk({tag, ".wb_data"}, wb_data, v.xdata);
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, v.xrd});
    chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, v.xwe});
    chk({tag, ".stalls"}, stalls, v.xstall);
    chk({tag, ".bus_error"}, {31'd0, bus_error}, {31'd0, v.xberr});
    chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    //          op     alu           addr       rd  dly rdata         xdata         xrd xwe st berr
    tbl[0] = '{5'd1,  32'hDEADBEEF, 17'h0,     7,  0,  32'h0,        32'hDEADBEEF, 7,  1,  0, 0};
    tbl[1] = '{5'd3,  32'h11,       17'h0,     0,  0,  32'h0,        32'h11,       0,  0,  0, 0};
    tbl[2] = '{5'd0,  32'h55,       17'h0,     9,  0,  32'h0,        32'h55,       9,  0,  0, 0};
    // ack lands in the last allowed REQ cycle: ack beats timeout
    tbl[3] = '{LD,    32'h0,        17'h1_0004, 3, 3,  32'h12345678, 32'h12345678, 3,  1,  4, 0};
    tbl[4] = '{LD,    32'h0,        17'h00123, 0,  0,  32'h0BADF00D, 32'h0BADF00D, 0,  0,  1, 0};
    tbl[5] = '{ST,    32'hCAFE0001, 17'h00010, 4,  0,  32'h0,        32'h0,        4,  0,  1, 0};
    tbl[6] = '{LD,    32'h0,        17'h1FFFF, 8,  99, 32'hFFFFFFFF, 32'h0,        8,  0,  TMO, 1};
    tbl[7] = '{5'd2,  32'h77,       17'h0,     1,  0,  32'h0,        32'h77,       1,  1,  0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst.stall", {31'd0, stall_out}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of a store; bus_error is set from the timeout above.
    alu_op_in = ST; alu_result_in = 32'h1234; memaddr_in = 17'h5; rd_in = 5'd2;
    @(posedge clk); @(negedge clk);
    chk("rmid.mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); @(negedge clk);
    reset = 1'b1; alu_op_in = 5'd0; alu_result_in = '0; rd_in = '0; memaddr_in = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rmid.wb_data", wb_data, 32'd0);
    chk("rmid.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rmid.wb_we", {31'd0, wb_we}, 32'd0);
    chk("rmid.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rmid.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rmid.mem_addr", {15'd0, mem_addr}, 32'd0);
    chk("rmid.mem_wdata", mem_wdata, 32'd0);
    chk("rmid.bus_error", {31'd0, bus_error}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk("stray.wb_data", wb_data, 32'd0);
    chk("stray.wb_we", {31'd0, wb_we}, 32'd0);
    chk("stray.mem_req", {31'd0, mem_req}, 32'd0);
    chk("stray.stall", {31'd0, stall_out}, 32'd0);

    // Halt raised during REQ: result parks in DONE until halt falls.
    run_op(model(5'd1, 32'h99, 17'h0, 5'd6, 0, 32'h0), "pre");
    alu_op_in = LD; memaddr_in = 17'h2A; rd_in = 5'd5; alu_result_in = '0;
    #1 chk("halt.issue_stall", {31'd0, stall_out}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("halt.mem_req", {31'd0, mem_req}, 32'd1);
    halted = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    #1 chk("halt.ack_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("halt.done_data", wb_data, 32'h99);
      chk("halt.done_we", {31'd0, wb_we}, 32'd1);
      chk("halt.done_rd", {27'd0, wb_rd}, 32'd6);
      chk("halt.done_stall", {31'd0, stall_out}, 32'd1);
      chk("halt.done_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    halted = 1'b0;
    #1 chk("halt.release_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); @(negedge clk);
    alu_op_in = 5'd1; alu_result_in = 32'hBAD; rd_in = 5'd3; halted = 1'b1;
    chk("halt.wb_data", wb_data, 32'hA5A5A5A5);
    chk("halt.wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("halt.wb_we", {31'd0, wb_we}, 32'd1);
    // Halted with an ALU op in IDLE: no stall, wb holds.
    #1 chk("hidle.stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("hidle.wb_data", wb_data, 32'hA5A5A5A5);
    halted = 1'b0;

    // Randomized ops against the transaction model.
    berr_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [4:0] op, rd;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? LD : (r < 7) ? ST : 5'($urandom_range(0, 19));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(model(op, $urandom, 17'($urandom), rd, $urandom_range(0, TMO + 1), $urandom),
             $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
